ldpc_stream_encoder: RTL and testbench

- Parametrised, sequential systematic block encoder for linear (N,K) LDPC/cyclic codes.
- Accepts information bits over several W-bit beats on a valid/ready input and accumulates parity one beat per cycle: each set info bit XORs its generator-matrix parity row into a P-bit accumulator.
- Presents the completed N-bit codeword {parity, info} on a valid/ready output.
- Replaces fixed combinational encoders in the codec datapath. Defaults implement the existing (15,7) code.

---
 rtl/ldpc_stream_encoder_if.sv | 14 +
 rtl/ldpc_stream_encoder.sv | 74 +++++++
 tb/tb_ldpc_stream_encoder.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/ldpc_stream_encoder_if.sv
// ldpc_stream_encoder_if: info-beat input and codeword output handshakes of the stream encoder.
interface ldpc_stream_encoder_if #(
   parameter int W = 1,
   parameter int N = 15
);
   logic [W-1:0] in_data;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] out_code;
   logic         out_valid;
   logic         out_ready;
   modport master(output in_data, in_valid, out_ready, input in_ready, out_code, out_valid);
   modport slave(input in_data, in_valid, out_ready, output in_ready, out_code, out_valid);
endinterface

// File: rtl/ldpc_stream_encoder.sv
// ldpc_stream_encoder: beat-serial systematic (N,K) block encoder; parity is accumulated one
// W-bit beat per cycle and the finished {parity, info} codeword is held on a valid/ready output.
module ldpc_stream_encoder #(
   parameter int K = 7,
   parameter int N = 15,
   parameter int W = 1,
   parameter logic [K*(N-K)-1:0] G_PAR = 56'hE8743A1DE673D1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   ldpc_stream_encoder_if.slave  io,
   output logic [15:0]           blk_count
);
   localparam int P = N - K;
   localparam int BEATS = K / W;
   localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
   if (K % W != 0) begin : g_bad
      $error("ldpc_stream_encoder: K must be a multiple of W");
   end
   logic [P-1:0]     acc, acc_next;
   logic [K-1:0]     info, info_next, hit, m;
   logic [K*P-1:0]   g;
   logic [BW-1:0]    beat_cnt;
   logic             last, in_fire, out_fire;
   assign last = beat_cnt == BW'(BEATS - 1);
   assign io.in_ready = !(last && io.out_valid && !io.out_ready);
   assign in_fire = io.in_valid && io.in_ready && !clr;
   assign out_fire = io.out_valid && io.out_ready;
   // Info bit r belongs to beat r/W, lane r%W.
   for (genvar r = 0; r < K; r++) begin : g_row
      logic sel;
      assign sel = beat_cnt == BW'(r / W);
      assign hit[r] = sel && io.in_data[r % W];
      assign info_next[r] = sel ? io.in_data[r % W] : info[r];
   end
   always_comb begin
      acc_next = acc;
      g = G_PAR;
      m = hit;
      for (int i = 0; i < K; i++) begin
         acc_next = m[0] ? acc_next ^ g[P-1:0] : acc_next;
         m = m >> 1;
         g = g >> P;
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         acc <= '0;
         info <= '0;
         beat_cnt <= '0;
         io.out_code <= '0;
         io.out_valid <= 1'b0;
         blk_count <= '0;
      end else begin
         if (clr) begin
            acc <= '0;
            info <= '0;
            beat_cnt <= '0;
         end else if (in_fire) begin
            acc <= last ? '0 : acc_next;
            info <= info_next;
            beat_cnt <= last ? '0 : beat_cnt + BW'(1);
         end
         // A completing beat reloads the output even while the previous word hands off.
         if (in_fire && last) begin
            io.out_code <= {acc_next, info_next};
            io.out_valid <= 1'b1;
         end else if (out_fire) begin
            io.out_valid <= 1'b0;
         end
         if (out_fire) blk_count <= blk_count + 16'd1;
      end
endmodule

// File: tb/tb_ldpc_stream_encoder.sv
// tb_ldpc_stream_encoder: scoreboard bench for a W=1 and a W=7 encoder instance of the (15,7) code.
module tb_ldpc_stream_encoder;
   logic        clk = 0;
   logic        rst_n = 0;
   logic        clr_a = 0;
   logic        clr_b = 0;
   logic [15:0] bc_a, bc_b;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [14:0] qa[$];
   logic [14:0] qb[$];

   ldpc_stream_encoder_if #(.W(1), .N(15)) ia();
   ldpc_stream_encoder_if #(.W(7), .N(15)) ib();

   ldpc_stream_encoder #(.K(7), .N(15), .W(1)) ua (
      .clk(clk), .rst_n(rst_n), .clr(clr_a), .io(ia.slave), .blk_count(bc_a));
   ldpc_stream_encoder #(.K(7), .N(15), .W(7)) ub (
      .clk(clk), .rst_n(rst_n), .clr(clr_b), .io(ib.slave), .blk_count(bc_b));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   function automatic logic [14:0] enc(input logic [6:0] info);
      logic [55:0] g = 56'hE8743A1DE673D1;
      logic [6:0]  v = info;
      logic [7:0]  p = '0;
      for (int r = 0; r < 7; r++) begin
         if (v[0]) p ^= g[7:0];
         v = v >> 1;
         g = g >> 8;
      end
      return {p, info};
   endfunction

   always @(negedge clk)
      if (rst_n && ia.out_valid && ia.out_ready) begin
         if (qa.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL code_a_unexpected: got %0h, required no output", ia.out_code);
         end else chk("code_a", ia.out_code, qa.pop_front());
      end

   always @(negedge clk)
      if (rst_n && ib.out_valid && ib.out_ready) begin
         if (qb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL code_b_unexpected: got %0h, required no output", ib.out_code);
         end else chk("code_b", ib.out_code, qb.pop_front());
      end

   task automatic send_beat(input logic d, output int t);
      t = 0;
      ia.in_data = d;
      ia.in_valid = 1;
      @(negedge clk);
      while (!ia.in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!ia.in_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL beat_timeout: in_ready got 0, required 1");
      end
      @(posedge clk);
      #1 ia.in_valid = 0;
   endtask

   task automatic send_blk(input logic [6:0] info, input logic [14:0] exp);
      logic [6:0] v = info;
      int t;
      qa.push_back(exp);
      for (int b = 0; b < 7; b++) begin
         send_beat(v[0], t);
         v = v >> 1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [6:0] dw[4] = '{7'h01, 7'h7F, 7'h08, 7'h00};
      logic [14:0] de[4] = '{15'h6881, 15'h7FFF, 15'h0E88, 15'h0000};
      logic [6:0] w;
      int t;
      ia.in_data = 0; ia.in_valid = 0; ia.out_ready = 0;
      ib.in_data = 0; ib.in_valid = 0; ib.out_ready = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      @(negedge clk);
      chk("rst_out_valid", ia.out_valid, 0);
      chk("rst_out_code", ia.out_code, 0);
      chk("rst_blk_count", bc_a, 0);
      chk("rst_in_ready", ia.in_ready, 1);

      // Basic encodes with hand-computed codewords.
      @(posedge clk);
      #1 ia.out_ready = 1;
      send_blk(7'h01, 15'h6881);
      chk("latency_valid", ia.out_valid, 1);
      @(posedge clk);
      #1 chk("blk_count_1", bc_a, 1);
      send_blk(7'h7F, 15'h7FFF);
      send_blk(7'h08, 15'h0E88);
      send_blk(7'h00, 15'h0000);
      chk("zero_valid", ia.out_valid, 1);
      repeat (2) @(posedge clk);
      #1 chk("blk_count_4", bc_a, 4);

      // Overlap: next block streams in while a codeword is held.
      ia.out_ready = 0;
      send_blk(7'h08, 15'h0E88);
      qa.push_back(15'h7FFF);
      for (int b = 0; b < 6; b++) begin
         send_beat(1, t);
         chk("overlap_no_stall", t, 0);
         chk("overlap_hold_valid", ia.out_valid, 1);
      end
      ia.in_data = 1;
      ia.in_valid = 1;
      @(negedge clk);
      chk("stall_ready", ia.in_ready, 0);
      @(posedge clk);
      #1 chk("stall_code", ia.out_code, 15'h0E88);
      chk("stall_valid", ia.out_valid, 1);
      ia.out_ready = 1;
      @(negedge clk);
      chk("release_ready", ia.in_ready, 1);
      @(posedge clk);
      #1 ia.in_valid = 0;
      chk("overlap_valid", ia.out_valid, 1);
      chk("overlap_code", ia.out_code, 15'h7FFF);
      chk("overlap_blk", bc_a, 5);
      @(posedge clk);
      #1 chk("overlap_drain", ia.out_valid, 0);
      chk("overlap_blk2", bc_a, 6);

      // clr aborts a partial block without touching the held output.
      ia.out_ready = 0;
      send_blk(7'h7F, 15'h7FFF);
      for (int b = 0; b < 3; b++) send_beat(1, t);
      clr_a = 1;
      ia.in_data = 1;
      ia.in_valid = 1;
      @(posedge clk);
      #1 clr_a = 0;
      ia.in_valid = 0;
      chk("clr_hold_valid", ia.out_valid, 1);
      chk("clr_hold_code", ia.out_code, 15'h7FFF);
      chk("clr_blk", bc_a, 6);
      ia.out_ready = 1;
      send_blk(7'h08, 15'h0E88);
      repeat (2) @(posedge clk);
      #1 chk("clr_blk2", bc_a, 8);

      // Single-beat instance: one codeword per cycle against the golden model.
      ib.out_ready = 1;
      for (int i = 0; i < 104; i++) begin
         w = i < 4 ? dw[i] : 7'($urandom);
         ib.in_data = w;
         ib.in_valid = 1;
         qb.push_back(i < 4 ? de[i] : enc(w));
         @(negedge clk);
         chk("b_ready", ib.in_ready, 1);
         @(posedge clk);
         #1;
      end
      ib.in_valid = 0;
      repeat (3) @(posedge clk);
      #1 chk("b_drained", qb.size(), 0);
      chk("b_blk", bc_b, 104);

      // Reset during beat 4 with a codeword held.
      ia.out_ready = 0;
      send_blk(7'h01, 15'h6881);
      for (int b = 0; b < 4; b++) send_beat(1, t);
      ia.in_data = 1;
      ia.in_valid = 1;
      #2 rst_n = 0;
      #1 chk("rst_mid_valid", ia.out_valid, 0);
      chk("rst_mid_blk", bc_a, 0);
      qa.delete();
      ia.in_valid = 0;
      @(posedge clk);
      #1 rst_n = 1;
      ia.out_ready = 1;
      send_blk(7'h7F, 15'h7FFF);
      repeat (2) @(posedge clk);
      #1 chk("rst_after_blk", bc_a, 1);
      chk("a_drained", qa.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
